// File: rtl/tx_msg_scheduler_pkg.sv
// Shared definitions for the UART message scheduler: FSM states, UART timing and ASCII constants.
package tx_msg_scheduler_pkg;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned BIT_RATE      = 9600;
  localparam int unsigned BIT_CYCLES    = CLK_HZ / BIT_RATE;
  localparam int unsigned MSG_BYTES_DEF = 16;
  localparam int unsigned LEN_W_DEF     = 5;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_FINISH
  } state_e;

  // Index width for a requester count; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_msg_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod NREQ.
module tx_msg_scheduler_rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt_c,
  output logic [IDX_W-1:0] idx_c
);

  logic             hit;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    hit   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NREQ);
      if (!hit && req[cand]) begin
        hit         = 1'b1;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/tx_msg_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among NREQ message sources.
module tx_msg_scheduler
  import tx_msg_scheduler_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MSG_BYTES = MSG_BYTES_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*MSG_BYTES*8-1:0] msg_data,
  input  logic [NREQ*LEN_W-1:0]       msg_len,
  output logic [NREQ-1:0]             grant,
  output logic [NREQ-1:0]             done,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  input  logic                        tx_busy,
  output logic                        busy
);

  localparam int unsigned IDX_W = idx_width(NREQ);
  localparam int unsigned MW    = MSG_BYTES * 8;

  state_e           state, state_n;
  logic [NREQ-1:0]  grant_n, done_n, arb_gnt_c;
  logic [IDX_W-1:0] g_idx, g_idx_n, rr_ptr, rr_ptr_n, arb_idx_c;
  logic [MW-1:0]    msg_q, msg_n, sel_msg_c;
  logic [LEN_W-1:0] len_q, len_n, idx_q, idx_n, sel_len_c, clamp_len_c;
  logic [7:0]       tx_data_n, cur_byte_c;
  logic             tx_start_n, busy_n;

  tx_msg_scheduler_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c)
  );

  // Message and length of the granted source.
  always_comb begin
    sel_msg_c = '0;
    sel_len_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (g_idx == IDX_W'(i)) begin
        sel_msg_c = msg_data[i*MW +: MW];
        sel_len_c = msg_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign clamp_len_c = (sel_len_c > LEN_W'(MSG_BYTES)) ? LEN_W'(MSG_BYTES) : sel_len_c;
  // Byte idx 0 sits in the most significant byte of the latched message.
  assign cur_byte_c  = 8'(msg_q >> {LEN_W'(MSG_BYTES - 1) - idx_q, 3'b000});

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    g_idx_n    = g_idx;
    rr_ptr_n   = rr_ptr;
    msg_n      = msg_q;
    len_n      = len_q;
    idx_n      = idx_q;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    done_n     = '0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          grant_n = arb_gnt_c;
          g_idx_n = arb_idx_c;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        msg_n   = sel_msg_c;
        len_n   = clamp_len_c;
        idx_n   = '0;
        state_n = (clamp_len_c == '0) ? ST_FINISH : ST_START;
      end
      // Hold off while a byte from before a reset is still shifting out.
      ST_START: begin
        if (!tx_busy) begin
          tx_data_n  = cur_byte_c;
          tx_start_n = 1'b1;
          state_n    = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) state_n = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          idx_n   = idx_q + LEN_W'(1);
          state_n = (idx_n == len_q) ? ST_FINISH : ST_START;
        end
      end
      ST_FINISH: begin
        done_n   = grant;
        grant_n  = '0;
        rr_ptr_n = (g_idx == IDX_W'(NREQ - 1)) ? '0 : g_idx + IDX_W'(1);
        state_n  = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      msg_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      done     <= done_n;
      tx_start <= tx_start_n;
      tx_data  <= tx_data_n;
      busy     <= busy_n;
      g_idx    <= g_idx_n;
      rr_ptr   <= rr_ptr_n;
      msg_q    <= msg_n;
      len_q    <= len_n;
      idx_q    <= idx_n;
    end
  end

endmodule
